// File: rtl/music_pkg.sv
// music_pkg: shared types, constants and note mapping for the music playback
// controller.
//
// Contents
//   state_t         playback FSM state (STOP, PLAY, PAUSE)
//   NOTE_W, DIV_W   note code width and note divider width
//   REST_DIV        divider value the note generator treats as silence
//   CODE_REST       score code for a rest
//   CODE_END        score code that marks the end of the score (code_b field only)
//   note_hz()       note code -> tone frequency in Hz (0 for non-tones)
//   code_to_div()   note code -> generator divider for a given clock frequency
package music_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int                NOTE_W    = 5;
  localparam int                DIV_W     = 22;
  localparam logic [DIV_W-1:0]  REST_DIV  = 22'd1000;
  localparam logic [NOTE_W-1:0] CODE_REST = 5'd0;
  localparam logic [NOTE_W-1:0] CODE_END  = 5'd31;

  // Codes 1..30 are a chromatic run from C4 upward, rounded to whole Hz.
  function automatic longint note_hz(input logic [NOTE_W-1:0] code);
    case (code)
      5'd1:    note_hz = 262;
      5'd2:    note_hz = 277;
      5'd3:    note_hz = 294;
      5'd4:    note_hz = 311;
      5'd5:    note_hz = 330;
      5'd6:    note_hz = 349;
      5'd7:    note_hz = 370;
      5'd8:    note_hz = 392;
      5'd9:    note_hz = 415;
      5'd10:   note_hz = 440;
      5'd11:   note_hz = 466;
      5'd12:   note_hz = 494;
      5'd13:   note_hz = 523;
      5'd14:   note_hz = 554;
      5'd15:   note_hz = 587;
      5'd16:   note_hz = 622;
      5'd17:   note_hz = 659;
      5'd18:   note_hz = 698;
      5'd19:   note_hz = 740;
      5'd20:   note_hz = 784;
      5'd21:   note_hz = 831;
      5'd22:   note_hz = 880;
      5'd23:   note_hz = 932;
      5'd24:   note_hz = 988;
      5'd25:   note_hz = 1047;
      5'd26:   note_hz = 1109;
      5'd27:   note_hz = 1175;
      5'd28:   note_hz = 1245;
      5'd29:   note_hz = 1319;
      5'd30:   note_hz = 1397;
      default: note_hz = 0;
    endcase
  endfunction

  // The generator toggles when its counter equals div, so its period is
  // 2*(div+1) clocks: div = clk_hz/(2*f) - 1. Rest (and a stray END code)
  // map to the silence sentinel.
  function automatic logic [DIV_W-1:0] code_to_div(input longint             clk_hz,
                                                   input logic [NOTE_W-1:0] code);
    longint f;
    longint d;
    f = note_hz(code);
    if (f == 0) return REST_DIV;
    d = clk_hz / (longint'(2) * f) - longint'(1);
    return d[DIV_W-1:0];
  endfunction

endpackage

// File: rtl/music_rom.sv
// music_rom: combinational score ROM.
//
// Each entry is a pair of note codes, one per generator channel. The written
// score is three entries long and is terminated by END at entry 3; every
// address past the written score also reads END.
//
// Ports
//   addr    in   ADDR_W  score address
//   code_b  out  NOTE_W  note code for channel b (END marks end of score)
//   code_c  out  NOTE_W  note code for channel c
module music_rom
  import music_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [NOTE_W-1:0] code_b,
  output logic [NOTE_W-1:0] code_c
);

  always_comb begin
    code_b = CODE_END;
    code_c = CODE_REST;
    case (addr)
      ADDR_W'(0): begin code_b = 5'd10;     code_c = 5'd5;      end
      ADDR_W'(1): begin code_b = 5'd12;     code_c = CODE_REST; end
      ADDR_W'(2): begin code_b = CODE_REST; code_c = 5'd8;      end
      default:    ;
    endcase
  end

endmodule

// File: rtl/music_ctrl.sv
// music_ctrl: playback controller for the two-channel square-wave note
// generator. Steps through the score ROM at a fixed beat rate, runs the
// play/pause/stop FSM and keeps a thermometer-coded volume level.
//
// Optional feature: define MUSIC_CTRL_TEMPO_EN to add the tempo_fast input,
// which halves the step length while it is high.
//
// Ports
//   clk         in   1       system clock
//   rst         in   1       asynchronous reset, active low
//   play        in   1       pulse: start, or resume from pause
//   pause       in   1       pulse: freeze playback
//   stop        in   1       pulse: halt and rewind to entry 0
//   vol_up      in   1       pulse: volume one step up
//   vol_dn      in   1       pulse: volume one step down
//   loop_en     in   1       level: wrap to entry 0 at end of score
//   tempo_fast  in   1       level: double speed (MUSIC_CTRL_TEMPO_EN only)
//   note_div_b  out  22      registered divider for channel b
//   note_div_c  out  22      registered divider for channel c
//   volume      out  4       thermometer-coded volume
//   playing     out  1       high while in PLAY
//   beat_idx    out  ADDR_W  current score address
module music_ctrl
  import music_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BEAT_HZ   = 8,
  parameter int SCORE_LEN = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         play,
  input  logic                         pause,
  input  logic                         stop,
  input  logic                         vol_up,
  input  logic                         vol_dn,
  input  logic                         loop_en,
`ifdef MUSIC_CTRL_TEMPO_EN
  input  logic                         tempo_fast,
`endif
  output logic [DIV_W-1:0]             note_div_b,
  output logic [DIV_W-1:0]             note_div_c,
  output logic [3:0]                   volume,
  output logic                         playing,
  output logic [$clog2(SCORE_LEN)-1:0] beat_idx
);

  localparam int BEAT_DIV = CLK_HZ / BEAT_HZ;
  localparam int ADDR_W   = $clog2(SCORE_LEN);
  localparam int CNT_W    = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] addr_inc;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [NOTE_W-1:0] cur_code_b;
  logic [NOTE_W-1:0] cur_code_c;
  logic [NOTE_W-1:0] nxt_code_b;
  logic [NOTE_W-1:0] unused_nxt_code_c;
  logic              tick_hit;
  logic              step_tick;
  logic              score_done;
  logic [DIV_W-1:0]  div_b_nxt;
  logic [DIV_W-1:0]  div_c_nxt;

  // Two read ports on the same score: the current entry drives the dividers,
  // the following entry is looked at only to detect END before stepping onto it.
  music_rom #(.ADDR_W(ADDR_W)) u_rom_cur (
    .addr   (addr),
    .code_b (cur_code_b),
    .code_c (cur_code_c)
  );

  music_rom #(.ADDR_W(ADDR_W)) u_rom_nxt (
    .addr   (addr_inc),
    .code_b (nxt_code_b),
    .code_c (unused_nxt_code_c)
  );

  assign addr_inc   = addr + ADDR_W'(1);
  assign score_done = (addr == ADDR_W'(SCORE_LEN - 1)) || (nxt_code_b == CODE_END);

`ifdef MUSIC_CTRL_TEMPO_EN
  // The >= comparison lets a step that is already past the half-way point
  // end immediately when fast tempo is switched on, instead of running on to
  // the full-length tick.
  assign tick_hit = tempo_fast ? (beat_cnt >= CNT_W'(BEAT_DIV / 2 - 1))
                               : (beat_cnt == CNT_W'(BEAT_DIV - 1));
`else
  assign tick_hit = (beat_cnt == CNT_W'(BEAT_DIV - 1));
`endif

  assign step_tick = (state == PLAY) && tick_hit;

  // State register, score address and beat counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= STOP;
      addr     <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  // Next state: stop beats pause beats play. A command that does not apply
  // to the current state falls through to normal counting.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    cnt_nxt   = beat_cnt;
    if (stop) begin
      state_nxt = STOP;
      addr_nxt  = '0;
      cnt_nxt   = '0;
    end else if (pause && (state == PLAY)) begin
      state_nxt = PAUSE;
    end else if (play && (state == STOP)) begin
      state_nxt = PLAY;
      addr_nxt  = '0;
      cnt_nxt   = '0;
    end else if (play && (state == PAUSE)) begin
      state_nxt = PLAY;
    end else if (state == PLAY) begin
      if (step_tick) begin
        cnt_nxt = '0;
        if (score_done) begin
          addr_nxt = '0;
          if (!loop_en) state_nxt = STOP;
        end else begin
          addr_nxt = addr_inc;
        end
      end else begin
        cnt_nxt = beat_cnt + CNT_W'(1);
      end
    end else if ((state != STOP) && (state != PAUSE)) begin
      // Unreachable encoding: fall back to the idle state.
      state_nxt = STOP;
      addr_nxt  = '0;
      cnt_nxt   = '0;
    end
  end

  // Outputs: playing follows the state register directly; the dividers are
  // computed here and registered below, so they trail playing by one cycle.
  always_comb begin
    playing   = (state == PLAY);
    div_b_nxt = REST_DIV;
    div_c_nxt = REST_DIV;
    if (state == PLAY) begin
      div_b_nxt = code_to_div(longint'(CLK_HZ), cur_code_b);
      div_c_nxt = code_to_div(longint'(CLK_HZ), cur_code_c);
    end
  end

  assign beat_idx = addr;

  // Divider output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      note_div_b <= REST_DIV;
      note_div_c <= REST_DIV;
    end else begin
      note_div_b <= div_b_nxt;
      note_div_c <= div_c_nxt;
    end
  end

  // Volume shifts a one in from the bottom going up and a zero in from the
  // top going down, which saturates at both ends for free. Simultaneous
  // up and down cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      volume <= 4'b0111;
    end else if (vol_up && !vol_dn) begin
      volume <= {volume[2:0], 1'b1};
    end else if (vol_dn && !vol_up) begin
      volume <= {1'b0, volume[3:1]};
    end
  end

endmodule
